// File: rtl/score_pulse_tx_pkg.sv
// rtl/score_pulse_tx_pkg.sv - shared state encodings, default pulse timings and timer sizing
package score_pulse_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } pulse_state_t;

    localparam int DEF_PULSE_HIGH_CYC = 50000;
    localparam int DEF_PULSE_LOW_CYC  = 50000;
    localparam int DEF_PEND_W         = 4;

    // One timer serves both phases, so it is sized for the longer of the two.
    function automatic int timer_width(input int hi_cyc, input int lo_cyc);
        int m;
        m = (hi_cyc > lo_cyc) ? hi_cyc : lo_cyc;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/score_pulse_tx.sv
// rtl/score_pulse_tx.sv - queues score strobes and emits one clean high/low pulse per event
module score_pulse_tx
    import score_pulse_tx_pkg::*;
#(
    parameter int PULSE_HIGH_CYC = DEF_PULSE_HIGH_CYC,
    parameter int PULSE_LOW_CYC  = DEF_PULSE_LOW_CYC,
    parameter int PEND_W         = DEF_PEND_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              score_evt,
    input  logic              clear,
    output logic              pulse_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int                 TMR_W     = timer_width(PULSE_HIGH_CYC, PULSE_LOW_CYC);
    localparam logic [TMR_W-1:0]   HIGH_LOAD = TMR_W'(PULSE_HIGH_CYC);
    localparam logic [TMR_W-1:0]   LOW_LOAD  = TMR_W'(PULSE_LOW_CYC);
    localparam logic [TMR_W-1:0]   TMR_ONE   = TMR_W'(1);
    localparam logic [PEND_W-1:0]  PEND_ONE  = PEND_W'(1);
    localparam logic [PEND_W-1:0]  PEND_MAX  = '1;

    pulse_state_t      r_state, w_state_nxt;
    logic              r_pulse, w_pulse_nxt;
    logic              r_busy;
    logic [TMR_W-1:0]  r_timer, w_timer_nxt;
    logic [PEND_W-1:0] r_pending, w_pending_nxt;
    logic              r_overflow, w_overflow_nxt;
    logic              w_timer_last;
    logic              w_slot;
    logic              w_avail;
    logic              w_launch;

    // A clear discards the queue, so only a same-cycle strobe may launch then.
    assign w_timer_last = (r_timer == TMR_ONE);
    assign w_slot       = (r_state == ST_IDLE) || ((r_state == ST_LOW) && w_timer_last);
    assign w_avail      = score_evt || ((r_pending != '0) && !clear);
    assign w_launch     = w_slot && w_avail;

    always_comb begin
        w_state_nxt = r_state;
        w_pulse_nxt = r_pulse;
        w_timer_nxt = r_timer;
        case (r_state)
            ST_IDLE: begin
                if (w_launch) begin
                    w_state_nxt = ST_HIGH;
                    w_pulse_nxt = 1'b1;
                    w_timer_nxt = HIGH_LOAD;
                end
            end
            ST_HIGH: begin
                if (w_timer_last) begin
                    w_state_nxt = ST_LOW;
                    w_pulse_nxt = 1'b0;
                    w_timer_nxt = LOW_LOAD;
                end else begin
                    w_timer_nxt = r_timer - TMR_ONE;
                end
            end
            ST_LOW: begin
                if (w_timer_last) begin
                    if (w_launch) begin
                        w_state_nxt = ST_HIGH;
                        w_pulse_nxt = 1'b1;
                        w_timer_nxt = HIGH_LOAD;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_pulse_nxt = 1'b0;
                        w_timer_nxt = '0;
                    end
                end else begin
                    w_timer_nxt = r_timer - TMR_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_pulse_nxt = 1'b0;
                w_timer_nxt = '0;
            end
        endcase
    end

    always_comb begin
        w_pending_nxt  = r_pending;
        w_overflow_nxt = r_overflow;
        if (clear) begin
            w_pending_nxt  = (score_evt && !w_launch) ? PEND_ONE : '0;
            w_overflow_nxt = 1'b0;
        end else if (score_evt && !w_launch) begin
            if (r_pending == PEND_MAX) begin
                w_overflow_nxt = 1'b1;
            end else begin
                w_pending_nxt = r_pending + PEND_ONE;
            end
        end else if (!score_evt && w_launch) begin
            w_pending_nxt = r_pending - PEND_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pulse    <= 1'b0;
            r_busy     <= 1'b0;
            r_timer    <= '0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pulse    <= w_pulse_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_timer    <= w_timer_nxt;
            r_pending  <= w_pending_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    assign pulse_out = r_pulse;
    assign busy      = r_busy;
    assign pending   = r_pending;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_score_pulse_tx.sv
// tb/tb_score_pulse_tx.sv - directed, table-driven bench for score_pulse_tx (HIGH=3, LOW=2, PEND_W=2)
module tb_score_pulse_tx;

    logic       clk;
    logic       rst_n;
    logic       score_evt;
    logic       clear;
    logic       pulse_out;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    int n_cmp;
    int n_fail;

    typedef struct {
        logic       evt;
        logic       clr;
        logic       exp_pulse;
        logic       exp_busy;
        logic [1:0] exp_pend;
        logic       exp_ovf;
    } vec_t;

    vec_t tbl[$];

    score_pulse_tx #(
        .PULSE_HIGH_CYC(3),
        .PULSE_LOW_CYC (2),
        .PEND_W        (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .score_evt(score_evt),
        .clear    (clear),
        .pulse_out(pulse_out),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish (got timeout, wanted $finish)");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic e, input logic c, input logic p,
                                input logic b, input logic [1:0] q, input logic o);
        vec_t v;
        v.evt = e; v.clr = c; v.exp_pulse = p; v.exp_busy = b; v.exp_pend = q; v.exp_ovf = o;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
    task automatic step(input logic e, input logic c);
        @(negedge clk);
        score_evt = e;
        clear     = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic p, input logic b,
                             input logic [1:0] q, input logic o);
        check({tag, ".pulse"}, 32'(pulse_out), 32'(p));
        check({tag, ".busy"}, 32'(busy), 32'(b));
        check({tag, ".pending"}, 32'(pending), 32'(q));
        check({tag, ".overflow"}, 32'(overflow), 32'(o));
    endtask

    initial begin
        int rises;
        int highs;
        logic prev;
        n_cmp     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        score_evt = 1'b0;
        clear     = 1'b0;

        // 1: strobes while held in reset are ignored
        for (int i = 0; i < 6; i++) begin
            step(logic'(i % 2 == 0), 1'b0);
            check_all($sformatf("rst[%0d]", i), 1'b0, 1'b0, 2'd0, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // 2: single event; 3: three consecutive strobes
        tbl.push_back(mk(1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 1, 0));
        tbl.push_back(mk(1, 0, 1, 1, 2, 0));
        tbl.push_back(mk(0, 0, 0, 1, 2, 0));
        tbl.push_back(mk(0, 0, 0, 1, 2, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].evt, tbl[i].clr);
            check_all($sformatf("vec[%0d]", i), tbl[i].exp_pulse, tbl[i].exp_busy,
                      tbl[i].exp_pend, tbl[i].exp_ovf);
        end

        // 4: six-strobe burst saturates the queue; the strobe landing on a relaunch is kept
        rises = 0;
        prev  = pulse_out;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0);
            check($sformatf("burst[%0d].pending", i), 32'(pending), (i < 3) ? 32'(i) : 32'd3);
            check($sformatf("burst[%0d].overflow", i), 32'(overflow), (i >= 4) ? 32'd1 : 32'd0);
            if (pulse_out && !prev) rises++;
            prev = pulse_out;
        end
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b0);
            if (pulse_out && !prev) rises++;
            prev = pulse_out;
        end
        check("burst.pulses", 32'(rises), 32'd5);
        check("burst.overflow_sticky", 32'(overflow), 32'd1);
        check("burst.drained", 32'(pending), 32'd0);
        check("burst.idle", 32'(busy), 32'd0);
        step(1'b0, 1'b1);
        check("burst.clear_ovf", 32'(overflow), 32'd0);

        // 5: clear with two queued drops the queue but lets the current pulse finish
        highs = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            if (pulse_out) highs++;
        end
        check("clr.pending_before", 32'(pending), 32'd2);
        step(1'b0, 1'b1);
        check("clr.full_width", 32'(highs), 32'd3);
        check("clr.fall", 32'(pulse_out), 32'd0);
        check("clr.pending_after", 32'(pending), 32'd0);
        check("clr.busy_low_phase", 32'(busy), 32'd1);
        rises = 0;
        prev  = pulse_out;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0);
            if (pulse_out && !prev) rises++;
            prev = pulse_out;
        end
        check("clr.no_more_pulses", 32'(rises), 32'd0);
        check("clr.idle", 32'(busy), 32'd0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("clr_evt.pending", 32'(pending), 32'd1);
        check("clr_evt.pulse", 32'(pulse_out), 32'd1);
        rises = 0;
        prev  = pulse_out;
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b0);
            if (pulse_out && !prev) rises++;
            prev = pulse_out;
        end
        check("clr_evt.kept_pulses", 32'(rises), 32'd1);
        check("clr_evt.drained", 32'(pending), 32'd0);

        // 6: asynchronous reset in the middle of a high phase
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("areset.pre_pending", 32'(pending), 32'd1);
        #2;
        score_evt = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_all("areset", 1'b0, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        highs = 0;
        step(1'b1, 1'b0);
        if (pulse_out) highs++;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0);
            if (pulse_out) highs++;
        end
        check("post_reset.width", 32'(highs), 32'd3);
        check_all("post_reset.end", 1'b0, 1'b0, 2'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
